// File: rtl/mem_bus_pkg.sv
// Shared types and helpers for the memory-map controller.
// Holds the FSM state encoding, wait-counter width and region decode helper.
package mem_bus_pkg;

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} mem_bus_state_t;

  localparam int WAIT_W = 4;

  function automatic logic [63:0] region_of(input logic [63:0] addr, input int unsigned shift);
    return addr >> shift;
  endfunction

endpackage

// File: rtl/mem_bus_decode.sv
// Combinational address decode: region index, region-local offset, unmapped and read-only checks.
// Zero latency; no handshake.
module mem_bus_decode
  import mem_bus_pkg::*;
#(
  parameter int AW = 32,
  parameter int NS = 3,
  parameter int REGION_SHIFT = 14,
  parameter logic [NS-1:0] RO_MASK = 3'b010,
  localparam int SELW = (NS > 1) ? $clog2(NS) : 1
) (
  input  logic [AW-1:0]           addr,
  input  logic                    we,
  output logic [SELW-1:0]         region,
  output logic [REGION_SHIFT-1:0] local_addr,
  output logic                    unmapped,
  output logic                    ro_violation
);

  logic [63:0] full_region;

  // Comparing the whole upper field catches any stray high address bit.
  assign full_region  = region_of(64'(addr), REGION_SHIFT);
  assign unmapped     = full_region >= 64'(NS);
  assign region       = full_region[SELW-1:0];
  assign local_addr   = addr[REGION_SHIFT-1:0];
  assign ro_violation = we && !unmapped && RO_MASK[region];

endmodule

// File: rtl/mem_bus_ctrl.sv
// Memory-map controller: decodes CPU accesses onto NS slave regions with per-region wait states.
// Optional error logging (err_addr/err_cnt) is built when MEM_BUS_ERRLOG_EN is defined.
module mem_bus_ctrl
  import mem_bus_pkg::*;
#(
  parameter int AW = 32,
  parameter int DW = 32,
  parameter int NS = 3,
  parameter int REGION_SHIFT = 14,
  parameter logic [NS*WAIT_W-1:0] WAIT_CYC = '0,
  parameter logic [NS-1:0] RO_MASK = 3'b010,
  localparam int SELW = (NS > 1) ? $clog2(NS) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cpu_req,
  input  logic                    cpu_we,
  input  logic [AW-1:0]           cpu_addr,
  input  logic [DW-1:0]           cpu_wdata,
  output logic [DW-1:0]           cpu_rdata,
  output logic                    cpu_ready,
  output logic                    cpu_err,
  output logic [SELW-1:0]         slv_sel,
  output logic [REGION_SHIFT-1:0] slv_addr,
  output logic [DW-1:0]           slv_wdata,
  output logic [NS-1:0]           slv_we,
  input  logic [NS*DW-1:0]        slv_rdata
`ifdef MEM_BUS_ERRLOG_EN
  ,
  output logic [AW-1:0]           err_addr,
  output logic [7:0]              err_cnt
`endif
);

  mem_bus_state_t state, state_nxt;

  logic [SELW-1:0]         dec_region;
  logic [REGION_SHIFT-1:0] dec_local;
  logic                    dec_unmapped;
  logic                    dec_ro;
  logic                    bad_req;
  logic                    accept;
  logic                    capture;
  logic                    we_q;
  logic                    err_q;
  logic [WAIT_W-1:0]       cnt;

  mem_bus_decode #(
    .AW(AW), .NS(NS), .REGION_SHIFT(REGION_SHIFT), .RO_MASK(RO_MASK)
  ) u_decode (
    .addr(cpu_addr),
    .we(cpu_we),
    .region(dec_region),
    .local_addr(dec_local),
    .unmapped(dec_unmapped),
    .ro_violation(dec_ro)
  );

  assign bad_req = dec_unmapped || dec_ro;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    capture   = 1'b0;
    slv_we    = '0;
    cpu_ready = 1'b0;
    cpu_err   = 1'b0;
    case (state)
      IDLE: begin
        if (cpu_req) begin
          accept    = 1'b1;
          state_nxt = bad_req ? DONE : ACCESS;
        end
      end
      ACCESS: begin
        if (cnt == '0) begin
          state_nxt = DONE;
          if (we_q) slv_we[slv_sel] = 1'b1;
          else      capture         = 1'b1;
        end
      end
      DONE: begin
        cpu_ready = 1'b1;
        cpu_err   = err_q;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Slave-facing fields only move on mapped requests so slv_sel never points past NS-1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slv_sel   <= '0;
      slv_addr  <= '0;
      slv_wdata <= '0;
      we_q      <= 1'b0;
      err_q     <= 1'b0;
      cnt       <= '0;
      cpu_rdata <= '0;
    end else if (accept) begin
      err_q     <= bad_req;
      cpu_rdata <= '0;
      if (!bad_req) begin
        slv_sel   <= dec_region;
        slv_addr  <= dec_local;
        slv_wdata <= cpu_wdata;
        we_q      <= cpu_we;
        cnt       <= WAIT_CYC[dec_region*WAIT_W +: WAIT_W];
      end else begin
        cnt <= '0;
      end
    end else if (state == ACCESS) begin
      if (cnt != '0) cnt <= cnt - 1'b1;
      if (capture)   cpu_rdata <= slv_rdata[slv_sel*DW +: DW];
    end
  end

`ifdef MEM_BUS_ERRLOG_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_addr <= '0;
      err_cnt  <= '0;
    end else if (accept && bad_req) begin
      err_addr <= cpu_addr;
      if (err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// Scoreboard bench for mem_bus_ctrl: driver pushes expected responses, a monitor checks each cpu_ready.
// Error-log ports are checked when MEM_BUS_ERRLOG_EN is defined.
module tb_mem_bus_ctrl;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          t_issue;
    logic        chk_rdata;
    logic        chk_slv;
    logic [1:0]  sel;
    logic [13:0] laddr;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_req;
  logic        cpu_we;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic [31:0] cpu_rdata;
  logic        cpu_ready;
  logic        cpu_err;
  logic [1:0]  slv_sel;
  logic [13:0] slv_addr;
  logic [31:0] slv_wdata;
  logic [2:0]  slv_we;
  logic [95:0] slv_rdata;
`ifdef MEM_BUS_ERRLOG_EN
  logic [31:0] err_addr;
  logic [7:0]  err_cnt;
`endif

  exp_t        exp_q[$];
  int          errors = 0;
  int          checks = 0;
  int          cyc = 0;
  int          we_pulses = 0;
  logic [2:0]  last_we = '0;
  logic [31:0] last_wdata = '0;

  mem_bus_ctrl #(
    .AW(32), .DW(32), .NS(3), .REGION_SHIFT(14),
    .WAIT_CYC(12'h300), .RO_MASK(3'b010)
  ) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready), .cpu_err(cpu_err),
    .slv_sel(slv_sel), .slv_addr(slv_addr), .slv_wdata(slv_wdata),
    .slv_we(slv_we), .slv_rdata(slv_rdata)
`ifdef MEM_BUS_ERRLOG_EN
    , .err_addr(err_addr), .err_cnt(err_cnt)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (slv_we != '0) begin
      we_pulses++;
      last_we    = slv_we;
      last_wdata = slv_wdata;
    end
  end

  always @(negedge clk) begin
    if (!rst && cpu_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_ready: got ready=1 want no response");
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("latency", 64'(cyc - e.t_issue), 64'(e.lat));
        chk("err", 64'(cpu_err), 64'(e.err));
        if (e.chk_rdata) chk("rdata", 64'(cpu_rdata), 64'(e.rdata));
        if (e.chk_slv) begin
          chk("slv_sel", 64'(slv_sel), 64'(e.sel));
          chk("slv_addr", 64'(slv_addr), 64'(e.laddr));
        end
      end
    end
  end

  task automatic access(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] erd, input logic eerr, input int elat,
                        input logic crd, input logic cslv, input logic [1:0] esel,
                        input logic [13:0] ela);
    exp_t e;
    logic seen;
    @(negedge clk);
    e.rdata = erd; e.err = eerr; e.lat = elat; e.t_issue = cyc;
    e.chk_rdata = crd; e.chk_slv = cslv; e.sel = esel; e.laddr = ela;
    exp_q.push_back(e);
    cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      seen = cpu_ready;
    end
    cpu_req = 1'b0;
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL timeout addr=%0h: got no ready want ready", addr);
      exp_q.delete();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int p0;
    rst = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    slv_rdata = {32'h2222_3333, 32'h0BAD_F00D, 32'hA5A5_0001};
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_ready", 64'(cpu_ready), 0);
    chk("rst_err", 64'(cpu_err), 0);
    chk("rst_rdata", 64'(cpu_rdata), 0);
    chk("rst_we", 64'(slv_we), 0);
    chk("rst_sel", 64'(slv_sel), 0);
    chk("rst_addr", 64'(slv_addr), 0);
    chk("rst_wdata", 64'(slv_wdata), 0);
`ifdef MEM_BUS_ERRLOG_EN
    chk("rst_err_addr", 64'(err_addr), 0);
    chk("rst_err_cnt", 64'(err_cnt), 0);
`endif

    access(1'b0, 32'h0000_0010, 32'h0, 32'hA5A5_0001, 1'b0, 2, 1'b1, 1'b1, 2'd0, 14'h0010);
    access(1'b0, 32'h0000_8001, 32'h0, 32'h2222_3333, 1'b0, 5, 1'b1, 1'b1, 2'd2, 14'h0001);

    p0 = we_pulses;
    access(1'b1, 32'h0000_0004, 32'hDEAD_BEEF, 32'h0, 1'b0, 2, 1'b0, 1'b1, 2'd0, 14'h0004);
    chk("wr_pulse_cnt", 64'(we_pulses - p0), 1);
    chk("wr_we", 64'(last_we), 64'(3'b001));
    chk("wr_wdata", 64'(last_wdata), 64'h0000_0000_DEAD_BEEF);

    access(1'b0, 32'h0000_C000, 32'h0, 32'h0, 1'b1, 1, 1'b1, 1'b0, 2'd0, 14'h0);
`ifdef MEM_BUS_ERRLOG_EN
    chk("log_addr", 64'(err_addr), 64'h0000_C000);
    chk("log_cnt", 64'(err_cnt), 1);
`endif

    p0 = we_pulses;
    access(1'b1, 32'h0000_4000, 32'h0000_0055, 32'h0, 1'b1, 1, 1'b0, 1'b0, 2'd0, 14'h0);
    chk("ro_pulse_cnt", 64'(we_pulses - p0), 0);

    access(1'b0, 32'h0000_4005, 32'h0, 32'h0BAD_F00D, 1'b0, 2, 1'b1, 1'b1, 2'd1, 14'h0005);
    access(1'b0, 32'h8000_0001, 32'h0, 32'h0, 1'b1, 1, 1'b1, 1'b0, 2'd0, 14'h0);
`ifdef MEM_BUS_ERRLOG_EN
    chk("log_cnt3", 64'(err_cnt), 3);
    chk("log_addr_hi", 64'(err_addr), 64'h8000_0001);
`endif

    // Reset lands in the second ACCESS cycle of a 3-wait write.
    p0 = we_pulses;
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h0000_8002; cpu_wdata = 32'h1234_5678;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    cpu_req = 1'b0;
    #1;
    chk("mid_rst_ready", 64'(cpu_ready), 0);
    chk("mid_rst_we", 64'(slv_we), 0);
    chk("mid_rst_sel", 64'(slv_sel), 0);
    chk("mid_rst_addr", 64'(slv_addr), 0);
    chk("mid_rst_wdata", 64'(slv_wdata), 0);
    chk("mid_rst_rdata", 64'(cpu_rdata), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    chk("mid_rst_no_pulse", 64'(we_pulses - p0), 0);

    access(1'b0, 32'h0000_0010, 32'h0, 32'hA5A5_0001, 1'b0, 2, 1'b1, 1'b1, 2'd0, 14'h0010);
`ifdef MEM_BUS_ERRLOG_EN
    chk("log_cnt_after_rst", 64'(err_cnt), 0);
`endif

    repeat (4) @(negedge clk);
    chk("sb_drained", 64'(exp_q.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
